// File: rtl/xbar_pkg.sv
// Shared types and constants for the stream crossbar output port.
// The optional packet counter (XBAR_OUT_PKT_CNT_EN) lives in xbar_output_port.
package xbar_pkg;

    localparam int XBAR_T_DATA_WIDTH = 8;
    localparam int XBAR_S_DATA_COUNT = 2;
    localparam int XBAR_M_DATA_COUNT = 3;

    // A single source still needs a 1-bit id field.
    function automatic int xbar_id_width(input int count);
        return (count > 1) ? $clog2(count) : 1;
    endfunction

    localparam int XBAR_T_ID_WIDTH = xbar_id_width(XBAR_S_DATA_COUNT);

    typedef enum logic [0:0] {
        XBAR_OUT_IDLE   = 1'b0,
        XBAR_OUT_LOCKED = 1'b1
    } xbar_out_state_e;

    typedef struct packed {
        logic [XBAR_T_DATA_WIDTH-1:0] data;
        logic                         last;
        logic [XBAR_T_ID_WIDTH-1:0]   id;
    } xbar_entry_t;

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry in-order FIFO with registered head and occupancy count.
// Pushes while full and pops while empty are ignored.
module stream_skid_fifo #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic [W-1:0] data_o,
    output logic         valid_o,
    output logic [1:0]   count_o
);

    logic [1:0][W-1:0] mem_q, mem_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              do_push, do_pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push_i && (count_q != 2'd2);
        do_pop   = pop_i && (count_q != 2'd0);
        if (do_push) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != 2'd0);
    assign count_o = count_q;

endmodule

// File: rtl/xbar_output_port.sv
// Crossbar output port: locks onto the granted source for a whole packet and buffers its beats.
// Defining XBAR_OUT_PKT_CNT_EN adds a saturating completed-packet counter on pkt_cnt_o.
module xbar_output_port
    import xbar_pkg::*;
#(
    parameter int  T_DATA_WIDTH = XBAR_T_DATA_WIDTH,
    parameter int  S_DATA_COUNT = XBAR_S_DATA_COUNT,
    parameter int  M_DATA_COUNT = XBAR_M_DATA_COUNT,
    localparam int T_ID___WIDTH = xbar_id_width(S_DATA_COUNT)
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic [S_DATA_COUNT-1:0]                  req_mask_i,
    input  logic [T_ID___WIDTH-1:0]                  grant_i,
    input  logic [S_DATA_COUNT-1:0][T_DATA_WIDTH-1:0] s_data_i,
    input  logic [S_DATA_COUNT-1:0]                  s_last_i,
    input  logic [S_DATA_COUNT-1:0]                  s_valid_i,
    output logic [S_DATA_COUNT-1:0]                  s_ready_o,
    output logic [T_DATA_WIDTH-1:0]                  m_data_o,
    output logic                                     m_last_o,
    output logic [T_ID___WIDTH-1:0]                  m_id_o,
    output logic                                     m_valid_o,
    input  logic                                     m_ready_i,
    output logic                                     busy_o,
    output logic                                     pkt_done_o
`ifdef XBAR_OUT_PKT_CNT_EN
    ,
    output logic [15:0]                              pkt_cnt_o
`endif
);

    if (S_DATA_COUNT < 1 || M_DATA_COUNT < 1) begin : g_bad_cfg
        $error("xbar_output_port needs at least one source and one output port");
    end

    typedef struct packed {
        logic [T_DATA_WIDTH-1:0] data;
        logic                    last;
        logic [T_ID___WIDTH-1:0] id;
    } entry_t;

    xbar_out_state_e         state_q, state_d;
    logic [T_ID___WIDTH-1:0] lock_id_q, lock_id_d;
    logic                    pkt_done_q, pkt_done_d;
    logic                    grant_req;
    logic                    accept;
    logic                    fifo_full;
    logic [1:0]              fifo_count;
    entry_t                  push_entry;
    entry_t                  head_entry;

    // Ready is derived from registered state only, so accept never depends on m_ready_i.
    assign fifo_full = (fifo_count == 2'd2);
    assign grant_req = (int'(grant_i) < S_DATA_COUNT) && req_mask_i[grant_i];
    assign accept    = (state_q == XBAR_OUT_LOCKED) && !fifo_full && s_valid_i[lock_id_q];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= XBAR_OUT_IDLE;
            lock_id_q  <= '0;
            pkt_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_id_q  <= lock_id_d;
            pkt_done_q <= pkt_done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        lock_id_d  = lock_id_q;
        pkt_done_d = 1'b0;
        case (state_q)
            XBAR_OUT_IDLE: begin
                if (grant_req) begin
                    state_d   = XBAR_OUT_LOCKED;
                    lock_id_d = grant_i;
                end
            end
            XBAR_OUT_LOCKED: begin
                if (accept && s_last_i[lock_id_q]) begin
                    state_d    = XBAR_OUT_IDLE;
                    pkt_done_d = 1'b1;
                end
            end
            default: state_d = XBAR_OUT_IDLE;
        endcase
    end

    always_comb begin
        s_ready_o = '0;
        busy_o    = 1'b0;
        if (state_q == XBAR_OUT_LOCKED) begin
            busy_o               = 1'b1;
            s_ready_o[lock_id_q] = !fifo_full;
        end
    end

    assign push_entry = '{data: s_data_i[lock_id_q], last: s_last_i[lock_id_q], id: lock_id_q};

    stream_skid_fifo #(
        .W ($bits(entry_t))
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (accept),
        .data_i  (push_entry),
        .pop_i   (m_valid_o && m_ready_i),
        .data_o  (head_entry),
        .valid_o (m_valid_o),
        .count_o (fifo_count)
    );

    assign m_data_o   = head_entry.data;
    assign m_last_o   = head_entry.last;
    assign m_id_o     = head_entry.id;
    assign pkt_done_o = pkt_done_q;

`ifdef XBAR_OUT_PKT_CNT_EN
    logic [15:0] pkt_cnt_q, pkt_cnt_d;

    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (pkt_done_q && (pkt_cnt_q != 16'hFFFF)) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pkt_cnt_q <= 16'd0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign pkt_cnt_o = pkt_cnt_q;
`else
`endif

endmodule

// File: tb/tb_xbar_output_port.sv
// Randomized bench for xbar_output_port with a packet-level reference model and per-source scoreboard.
// Define XBAR_OUT_PKT_CNT_EN to also exercise the packet counter.
module tb_xbar_output_port;

    localparam int W   = 8;
    localparam int S   = 2;
    localparam int IDW = 1;

    logic                  clk = 1'b0;
    logic                  rst_i;
    logic [S-1:0]          req_mask_i;
    logic [IDW-1:0]        grant_i;
    logic [S-1:0][W-1:0]   s_data_i;
    logic [S-1:0]          s_last_i;
    logic [S-1:0]          s_valid_i;
    logic [S-1:0]          s_ready_o;
    logic [W-1:0]          m_data_o;
    logic                  m_last_o;
    logic [IDW-1:0]        m_id_o;
    logic                  m_valid_o;
    logic                  m_ready_i;
    logic                  busy_o;
    logic                  pkt_done_o;
`ifdef XBAR_OUT_PKT_CNT_EN
    logic [15:0]           pkt_cnt_o;
`endif

    xbar_output_port dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .req_mask_i (req_mask_i),
        .grant_i    (grant_i),
        .s_data_i   (s_data_i),
        .s_last_i   (s_last_i),
        .s_valid_i  (s_valid_i),
        .s_ready_o  (s_ready_o),
        .m_data_o   (m_data_o),
        .m_last_o   (m_last_o),
        .m_id_o     (m_id_o),
        .m_valid_o  (m_valid_o),
        .m_ready_i  (m_ready_i),
        .busy_o     (busy_o),
        .pkt_done_o (pkt_done_o)
`ifdef XBAR_OUT_PKT_CNT_EN
        ,
        .pkt_cnt_o  (pkt_cnt_o)
`endif
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int checks   = 0;
    int failures = 0;

    logic [W:0] src_q0[$], src_q1[$];   // beats still to be offered by each source
    logic [W:0] exp_q0[$], exp_q1[$];   // beats each source expects to see on the output

    int         valid_pct   = 100;
    int         ready_pct   = 100;
    int         fixed_grant = -1;

    bit         md_locked;
    int         md_lock;
    int         md_occ;
    bit         md_done;
    int         cyc;
    int         acc_cnt;
    int         done_cnt;
    bit         cur_open;
    int         cur_id;
    bit         prev_stall;
    logic [IDW+W:0] prev_head;

    int         log_cyc[$];
    int         log_id[$];
    logic [W:0] log_beat[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int src_size(input int j);
        return (j == 0) ? src_q0.size() : src_q1.size();
    endfunction

    function automatic logic [W:0] src_front(input int j);
        return (j == 0) ? src_q0[0] : src_q1[0];
    endfunction

    function automatic int exp_size(input int j);
        return (j == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    task automatic push_pkt(input int j, input int len, input logic [W-1:0] base, input bit rnd);
        logic [W:0] b;
        for (int i = 0; i < len; i++) begin
            b = {(i == len - 1), rnd ? W'($urandom) : W'(base + W'(i))};
            if (j == 0) begin
                src_q0.push_back(b);
                exp_q0.push_back(b);
            end else begin
                src_q1.push_back(b);
                exp_q1.push_back(b);
            end
        end
    endtask

    task automatic clear_all();
        src_q0.delete(); src_q1.delete();
        exp_q0.delete(); exp_q1.delete();
        md_locked = 1'b0; md_occ = 0; md_done = 1'b0;
        cur_open = 1'b0; prev_stall = 1'b0;
    endtask

    // ---------------- driver ----------------
    task automatic drive();
        logic [W:0] b;
        for (int j = 0; j < S; j++) begin
            if (src_size(j) > 0) begin
                b = src_front(j);
                s_valid_i[j]  = ($urandom_range(99, 0) < valid_pct);
                req_mask_i[j] = 1'b1;
            end else begin
                b = {1'b0, W'($urandom)};
                s_valid_i[j]  = 1'b0;
                req_mask_i[j] = 1'b0;
            end
            s_last_i[j] = b[W];
            s_data_i[j] = b[W-1:0];
        end
        grant_i   = (fixed_grant >= 0) ? fixed_grant[IDW-1:0] : IDW'($urandom_range(S - 1, 0));
        m_ready_i = ($urandom_range(99, 0) < ready_pct);
    endtask

    // ---------------- monitor + reference model (mid-cycle) ----------------
    task automatic monitor();
        logic [S-1:0] exp_rdy;
        logic [W:0]   beat;
        logic [W:0]   want;
        int           acc;
        int           pop;
        int           id;
        cyc++;
        if (rst_i) begin
            clear_all();
            return;
        end
        exp_rdy = '0;
        if (md_locked && md_occ < 2) exp_rdy[md_lock] = 1'b1;
        chk("s_ready", s_ready_o, exp_rdy);
        chk("busy", busy_o, md_locked);
        chk("m_valid", m_valid_o, (md_occ > 0));
        chk("pkt_done", pkt_done_o, md_done);
        if (pkt_done_o) done_cnt++;
        if (prev_stall) chk("stall_hold", {m_valid_o, m_id_o, m_last_o, m_data_o}, {1'b1, prev_head});

        if (m_valid_o && m_ready_i) begin
            beat = {m_last_o, m_data_o};
            id   = int'(m_id_o);
            if (cur_open) chk("no_interleave", m_id_o, cur_id);
            if (exp_size(id) == 0) begin
                chk("unexpected_beat", exp_size(id), 1);
            end else begin
                want = (id == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                chk("beat", beat, want);
            end
            log_cyc.push_back(cyc);
            log_id.push_back(id);
            log_beat.push_back(beat);
            cur_open = !m_last_o;
            cur_id   = id;
        end
        prev_stall = m_valid_o && !m_ready_i;
        prev_head  = {m_id_o, m_last_o, m_data_o};

        for (int j = 0; j < S; j++) begin
            if (s_valid_i[j] && s_ready_o[j]) begin
                acc_cnt++;
                if (j == 0) void'(src_q0.pop_front());
                else        void'(src_q1.pop_front());
            end
        end

        acc     = (md_locked && md_occ < 2 && s_valid_i[md_lock]) ? 1 : 0;
        pop     = (md_occ > 0 && m_ready_i) ? 1 : 0;
        md_done = (acc == 1) && s_last_i[md_lock];
        if (!md_locked) begin
            if (req_mask_i[grant_i]) begin
                md_locked = 1'b1;
                md_lock   = int'(grant_i);
            end
        end else if (md_done) begin
            md_locked = 1'b0;
        end
        md_occ = md_occ + acc - pop;
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic check_reset_vals();
        chk("rst_s_ready", s_ready_o, 0);
        chk("rst_m_valid", m_valid_o, 0);
        chk("rst_m_data", m_data_o, 0);
        chk("rst_m_last", m_last_o, 0);
        chk("rst_m_id", m_id_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_pkt_done", pkt_done_o, 0);
`ifdef XBAR_OUT_PKT_CNT_EN
        chk("rst_pkt_cnt", pkt_cnt_o, 0);
`endif
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        repeat (2) cycle();
        rst_i = 1'b0;
        check_reset_vals();
    endtask

    task automatic drain(input string tag, input int bound);
        int n = 0;
        while ((src_q0.size() + src_q1.size() + exp_q0.size() + exp_q1.size() + md_occ) > 0 && n < bound) begin
            cycle();
            n++;
        end
        chk(tag, src_q0.size() + src_q1.size() + exp_q0.size() + exp_q1.size(), 0);
        repeat (3) cycle();
    endtask

    // ---------------- main sequence ----------------
    int         t0;
    int         d0;
    int         a0;
    int         sent;
    int         n;
    int         jj;
    logic [W:0] want_b;

    initial begin
        rst_i = 1'b1;
        drive();
        do_reset();

        // Single 4-beat packet from source 1, output always ready.
        fixed_grant = 1; valid_pct = 100; ready_pct = 100;
        log_cyc.delete(); log_id.delete(); log_beat.delete();
        d0 = done_cnt; t0 = cyc;
        push_pkt(1, 4, 8'hA1, 1'b0);
        drive();
        drain("t1_drained", 50);
        chk("t1_beats", log_beat.size(), 4);
        if (log_beat.size() == 4) begin
            chk("t1_first_latency", log_cyc[0] - t0, 3);
            for (int i = 0; i < 4; i++) begin
                want_b = {(i == 3), W'(8'hA1 + i)};
                chk("t1_data", log_beat[i], want_b);
                chk("t1_id", log_id[i], 1);
                if (i > 0) chk("t1_consecutive", log_cyc[i] - log_cyc[i-1], 1);
            end
        end
        chk("t1_done_pulses", done_cnt - d0, 1);

        // Both sources request; grant moves to 1 in the middle of source 0's packet.
        fixed_grant = 0;
        log_cyc.delete(); log_id.delete(); log_beat.delete();
        push_pkt(0, 4, 8'hB0, 1'b0);
        push_pkt(1, 2, 8'hC0, 1'b0);
        drive();
        repeat (2) cycle();
        fixed_grant = 1;
        drain("t2_drained", 60);
        chk("t2_beats", log_beat.size(), 6);
        if (log_beat.size() == 6) begin
            for (int i = 0; i < 6; i++) chk("t2_order_id", log_id[i], (i < 4) ? 0 : 1);
            chk("t2_idle_gap", log_cyc[4] - log_cyc[3], 2);
        end

        // Output stalled: exactly two beats may be taken, then ready drops.
        fixed_grant = 0; ready_pct = 0;
        log_cyc.delete(); log_id.delete(); log_beat.delete();
        push_pkt(0, 6, 8'h30, 1'b0);
        drive();
        a0 = acc_cnt;
        repeat (7) cycle();
        chk("t3_buffered", acc_cnt - a0, 2);
        chk("t3_ready_low", s_ready_o, 0);
        chk("t3_valid_held", m_valid_o, 1);
        ready_pct = 100;
        drain("t3_drained", 60);
        chk("t3_beats", log_beat.size(), 6);

        // Randomized traffic: 100 packets, 50% output ready, random grants.
        fixed_grant = -1; valid_pct = 80; ready_pct = 50;
        d0 = done_cnt; sent = 0; n = 0;
        while (sent < 100 && n < 20000) begin
            jj = int'($urandom_range(S - 1, 0));
            if (src_size(jj) == 0 && $urandom_range(3, 0) != 0) begin
                push_pkt(jj, int'($urandom_range(4, 1)), '0, 1'b1);
                sent++;
            end
            cycle();
            n++;
        end
        drain("t4_drained", 5000);
        chk("t4_pkt_done_count", done_cnt - d0, 100);

        // Reset in the middle of a packet: nothing of it may reappear.
        fixed_grant = 1; valid_pct = 100; ready_pct = 100;
        push_pkt(1, 4, 8'h50, 1'b0);
        drive();
        a0 = acc_cnt; n = 0;
        while (acc_cnt - a0 < 2 && n < 20) begin
            cycle();
            n++;
        end
        chk("t5_two_beats_in", acc_cnt - a0, 2);
        rst_i = 1'b1;
        cycle();
        rst_i = 1'b0;
        check_reset_vals();
        log_cyc.delete(); log_id.delete(); log_beat.delete();
        repeat (10) cycle();
        chk("t5_no_remnants", log_beat.size(), 0);
        fixed_grant = 0;
        push_pkt(0, 2, 8'h60, 1'b0);
        drive();
        drain("t5_drained", 40);
        chk("t5_beats", log_beat.size(), 2);
        if (log_beat.size() == 2) chk("t5_first", log_beat[0], {1'b0, 8'h60});

`ifdef XBAR_OUT_PKT_CNT_EN
        do_reset();
        for (int p = 0; p < 3; p++) push_pkt(p % 2, 2, W'(8'h70 + p), 1'b0);
        fixed_grant = -1;
        drive();
        drain("t6_drained", 100);
        chk("t6_pkt_cnt", pkt_cnt_o, 3);
        force dut.pkt_cnt_q = 16'hFFFF;
        cycle();
        release dut.pkt_cnt_q;
        push_pkt(0, 1, 8'h7F, 1'b0);
        drive();
        drain("t6b_drained", 40);
        chk("t6_pkt_cnt_sat", pkt_cnt_o, 16'hFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xbar_output_port.md
# xbar_output_port

Per-output-port data path of the stream crossbar: consumes the source id chosen by that port's round-robin arbiter, locks onto that source for a whole packet, multiplexes its beats onto the output stream through a 2-entry buffer, and returns per-source ready. One instance per output port; each instance's `s_ready_o` is OR-reduced externally per source. `pkt_done_o` tells the arbiter when a packet has completed so it can rotate.

## Interface
- `T_DATA_WIDTH`, 8, data width per beat
- `S_DATA_COUNT`, 2, number of source (input) streams
- `M_DATA_COUNT`, 3, number of output ports (sets `T_DEST_WIDTH` only)
- `T_ID___WIDTH` (localparam), `$clog2(S_DATA_COUNT)`

Ports:
- `clk_i`  in  1  clock; one clock domain.
- `rst_i`  in  1  reset; synchronous, active-high.
- `req_mask_i`  in  S_DATA_COUNT  bit j = source j is valid and targets this port
- `grant_i`  in  T_ID___WIDTH  arbiter-selected source id
- `s_data_i`  in  T_DATA_WIDTH x S_DATA_COUNT  source data array
- `s_last_i`  in  S_DATA_COUNT  source end-of-packet
- `s_valid_i`  in  S_DATA_COUNT  source valid
- `s_ready_o`  out  S_DATA_COUNT  ready toward sources; at most one bit high
- `m_data_o`  out  T_DATA_WIDTH  output data
- `m_last_o`  out  1  output end-of-packet
- `m_id_o`  out  T_ID___WIDTH  source id of the beat on the output
- `m_valid_o`  out  1  output valid
- `m_ready_i`  in  1  output ready
- `busy_o`  out  1  packet lock held
- `pkt_done_o`  out  1  one-cycle pulse: last beat accepted from the locked source

## Operation
- FSM states: IDLE, LOCKED. `lock_id` register holds the locked source.
- IDLE: if `req_mask_i[grant_i]`=1, latch `lock_id`<=`grant_i`, go to LOCKED next cycle. No `s_ready_o` bit is high in IDLE.
- LOCKED: `s_ready_o[lock_id]` = buffer count < 2; all other bits 0. Accept = `s_valid_i[lock_id] && s_ready_o[lock_id]`; pushes {data, last, lock_id} into the buffer.
- Accepted beat with `s_last_i[lock_id]`=1: `pkt_done_o`=1 the next cycle; FSM returns to IDLE. A new lock can be taken in the cycle after that IDLE cycle is entered (one idle cycle minimum between packets).
- `grant_i` and `req_mask_i` are ignored in LOCKED; changing them mid-packet has no effect.
- Buffer: 2-entry FIFO, in-order. `m_valid_o` = not empty; head on `m_*`; pop on `m_valid_o && m_ready_i`. Push and pop in the same cycle keeps count unchanged, including at count 2 (push is not allowed at count 2 since ready is 0).
- `m_*` outputs stay stable while `m_valid_o && !m_ready_i`.
- Beats of one packet are never interleaved with another source.

## Timing
- Reset values: `s_ready_o`=0, `m_valid_o`=0, `m_data_o`=0, `m_last_o`=0, `m_id_o`=0, `busy_o`=0, `pkt_done_o`=0; FSM IDLE, count 0.
- Reset mid-packet: buffer contents and lock are discarded; no partial beats emitted afterward.
- Grant-to-first-ready: 1 cycle (IDLE sample, ready in LOCKED cycle).
- Accept-to-output latency: 1 cycle (registered buffer).
- Throughput: 1 beat/cycle sustained with `m_ready_i`=1.
- `s_ready_o` depends only on registered state (no combinational path from `m_ready_i`).

## Configuration
- `XBAR_OUT_PKT_CNT_EN` defined: adds output `pkt_cnt_o` [15:0], increments on every `pkt_done_o`, saturates at 16'hFFFF, resets to 0.
- Not defined: port and counter are absent; all other behaviour is identical.

## Structure
- Package `xbar_pkg`: FSM state enum (`XBAR_OUT_IDLE`, `XBAR_OUT_LOCKED`), buffer entry struct {data, last, id}, width helper constants.
- Sub-module `stream_skid_fifo`: 2-entry FIFO with count, push/pop, registered outputs, synchronous active-high reset.

## Test plan
- Source 1 sends a 4-beat packet (0xA1..0xA4, last on 4th), `grant_i`=1, `m_ready_i`=1 -> `m_data_o` A1..A4 on consecutive cycles, `m_id_o`=1, `m_last_o` only on A4, `pkt_done_o` one pulse.
- Sources 0 and 1 both requesting, `grant_i` switches 0->1 mid-packet of source 0 -> source 0 packet completes uninterrupted; source 1 is served only after IDLE.
- `m_ready_i`=0 for 5 cycles during a packet -> exactly 2 beats buffered, `s_ready_o`=0, no loss or reorder when released.
- Random `m_ready_i` (50%) over 100 packets -> output equals input stream per source, no interleaving.
- `rst_i` asserted at beat 2 of 4 -> all outputs at reset values next cycle; no remnant beats afterward.
- With `XBAR_OUT_PKT_CNT_EN`: 3 packets -> `pkt_cnt_o`=3; forced to 16'hFFFF then one more packet -> stays 16'hFFFF.
